// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_DM = 2'd1,
    BUSY_IF = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DM = 1'b1
  } arb_src_e;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts busy cycles of the memory request; expired marks the last allowed
// cycle so the arbiter can leave BUSY at the edge that ends it.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the number of busy cycles already completed
  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// outstanding transaction at a time, data side has priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_if_req,
  input  logic [AW-1:0]   i_if_addr,
  output logic            o_if_valid,
  output logic [DW-1:0]   o_if_rdata,
  input  logic            i_dm_req,
  input  logic            i_dm_we,
  input  logic [DW/8-1:0] i_dm_be,
  input  logic [AW-1:0]   i_dm_addr,
  input  logic [DW-1:0]   i_dm_wdata,
  output logic            o_dm_valid,
  output logic [DW-1:0]   o_dm_rdata,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [DW/8-1:0] o_mem_be,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  input  logic            i_mem_ack,
  input  logic [DW-1:0]   i_mem_rdata,
  output logic            o_err,
  output logic            o_err_src
);

  arb_state_e state, state_nx;
  arb_src_e   cur_src;
  logic       busy;
  logic       wd_expired;

  assign busy    = (state == BUSY_DM) || (state == BUSY_IF);
  assign cur_src = (state == BUSY_DM) ? SRC_DM : SRC_IF;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!busy),
    .enable  (busy),
    .expired (wd_expired)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (i_dm_req)      state_nx = BUSY_DM;
        else if (i_if_req) state_nx = BUSY_IF;
      end
      BUSY_DM, BUSY_IF: begin
        if (i_mem_ack || wd_expired) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Outputs are all registered off the state transition being taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_if_valid  <= 1'b0;
      o_if_rdata  <= '0;
      o_dm_valid  <= 1'b0;
      o_dm_rdata  <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_be    <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_err       <= 1'b0;
      o_err_src   <= 1'b0;
    end else begin
      o_if_valid <= 1'b0;
      o_dm_valid <= 1'b0;
      if ((state == IDLE) && (state_nx == BUSY_DM)) begin
        o_mem_req   <= 1'b1;
        o_mem_we    <= i_dm_we;
        o_mem_be    <= i_dm_be;
        o_mem_addr  <= i_dm_addr;
        o_mem_wdata <= i_dm_wdata;
      end else if ((state == IDLE) && (state_nx == BUSY_IF)) begin
        o_mem_req   <= 1'b1;
        o_mem_we    <= 1'b0;
        o_mem_be    <= '1;
        o_mem_addr  <= i_if_addr;
        o_mem_wdata <= '0;
      end else if (busy && (state_nx == RESP)) begin
        // An ack in the final watchdog cycle still counts as a completion.
        o_mem_req <= 1'b0;
        if (cur_src == SRC_DM) begin
          o_dm_valid <= 1'b1;
          if (!o_mem_we) o_dm_rdata <= i_mem_ack ? i_mem_rdata : '0;
        end else begin
          o_if_valid <= 1'b1;
          o_if_rdata <= i_mem_ack ? i_mem_rdata : '0;
        end
        if (!i_mem_ack) begin
          o_err     <= 1'b1;
          o_err_src <= cur_src;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_if_req = 1'b0;
  logic [AW-1:0] i_if_addr = '0;
  logic          o_if_valid;
  logic [DW-1:0] o_if_rdata;
  logic          i_dm_req = 1'b0;
  logic          i_dm_we = 1'b0;
  logic [3:0]    i_dm_be = '0;
  logic [AW-1:0] i_dm_addr = '0;
  logic [DW-1:0] i_dm_wdata = '0;
  logic          o_dm_valid;
  logic [DW-1:0] o_dm_rdata;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [3:0]    o_mem_be;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_ack;
  logic [DW-1:0] i_mem_rdata = '0;
  logic          o_err;
  logic          o_err_src;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_be(i_dm_be),
    .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
    .o_dm_valid(o_dm_valid), .o_dm_rdata(o_dm_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_err(o_err), .o_err_src(o_err_src)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after mem_wait request cycles unless silent.
  int            mem_wait = 0;
  logic          mem_silent = 1'b0;
  logic [DW-1:0] mem_rdata_val = '0;
  logic          mem_ack_r = 1'b0;
  logic          late_ack_stim = 1'b0;
  int            wcnt = 0;

  assign i_mem_ack = mem_ack_r | late_ack_stim;

  always @(posedge clk) begin
    #1;
    mem_ack_r = 1'b0;
    if (o_mem_req && !mem_silent) begin
      if (wcnt == mem_wait) begin
        mem_ack_r   = 1'b1;
        i_mem_rdata = mem_rdata_val;
        wcnt        = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Reference model: one in-flight transaction record, a response slot, and
  // the latched memory fields the port should be presenting.
  logic          m_inflight = 0, m_respond = 0, m_src = 0;
  int            m_age = 0;
  logic          m_mem_req = 0, m_we = 0, m_if_valid = 0, m_dm_valid = 0;
  logic [3:0]    m_be = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_if_rdata = '0, m_dm_rdata = '0;
  logic          m_err = 0, m_err_src = 0;

  task automatic model_complete(input logic acked);
    logic [DW-1:0] data;
    data = acked ? i_mem_rdata : '0;
    m_inflight = 0;
    m_respond  = 1;
    m_mem_req  = 0;
    if (m_src) begin
      m_dm_valid = 1;
      if (!m_we) m_dm_rdata = data;
    end else begin
      m_if_valid = 1;
      m_if_rdata = data;
    end
    if (!acked) begin
      m_err     = 1;
      m_err_src = m_src;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight = 0; m_respond = 0; m_src = 0; m_age = 0;
      m_mem_req = 0; m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
      m_if_valid = 0; m_dm_valid = 0; m_if_rdata = '0; m_dm_rdata = '0;
      m_err = 0; m_err_src = 0;
    end else begin
      m_if_valid = 0;
      m_dm_valid = 0;
      if (m_inflight) begin
        m_age++;
        if (i_mem_ack)              model_complete(1'b1);
        else if (m_age == TIMEOUT)  model_complete(1'b0);
      end else if (m_respond) begin
        m_respond = 0;
      end else if (i_dm_req || i_if_req) begin
        m_inflight = 1;
        m_age      = 0;
        m_mem_req  = 1;
        m_src      = i_dm_req;
        m_we       = i_dm_req ? i_dm_we : 1'b0;
        m_be       = i_dm_req ? i_dm_be : 4'hF;
        m_addr     = i_dm_req ? i_dm_addr : i_if_addr;
        m_wdata    = i_dm_req ? i_dm_wdata : '0;
      end
    end
  end

  logic chk_en = 1'b0;
  int   req_hi = 0, ifv_cnt = 0, dmv_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", o_mem_req, m_mem_req);
      check("if_valid", o_if_valid, m_if_valid);
      check("dm_valid", o_dm_valid, m_dm_valid);
      check("if_rdata", o_if_rdata, m_if_rdata);
      check("dm_rdata", o_dm_rdata, m_dm_rdata);
      check("err", o_err, m_err);
      check("err_src", o_err_src, m_err_src);
      check("mem_we", o_mem_we, m_we);
      check("mem_be", o_mem_be, m_be);
      check("mem_addr", o_mem_addr, m_addr);
      check("mem_wdata", o_mem_wdata, m_wdata);
      if (o_mem_req)  req_hi++;
      if (o_if_valid) ifv_cnt++;
      if (o_dm_valid) dmv_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic dm, input int budget, input string name);
    int n;
    n = 0;
    while (!(dm ? o_dm_valid : o_if_valid) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (!(dm ? o_dm_valid : o_if_valid)) begin
      miscompares++;
      $display("FAIL %s: valid not seen within %0d cycles, required a pulse", name, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required $finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base, ifb, dmb;
    time t_prev, t_now;
    logic [AW-1:0] a;

    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) tick();
    check("rst_mem_req", o_mem_req, 0);
    check("rst_err", o_err, 0);
    check("rst_dm_rdata", o_dm_rdata, 0);
    rst_n = 1'b1;
    tick();

    // DM read with two wait cycles
    mem_wait = 2; mem_rdata_val = 32'hDEADBEEF;
    base = req_hi; ifb = ifv_cnt;
    i_dm_req = 1; i_dm_we = 0; i_dm_be = 4'hF; i_dm_addr = 32'h100;
    wait_valid(1'b1, 20, "t1_dm_valid");
    i_dm_req = 0;
    check("t1_rdata", o_dm_rdata, 32'hDEADBEEF);
    check("t1_req_cycles", req_hi - base, 3);
    tick();
    check("t1_if_quiet", ifv_cnt - ifb, 0);
    tick();

    // Simultaneous IF and DM: DM first
    mem_wait = 1; mem_rdata_val = 32'hCAFE0002;
    ifb = ifv_cnt; dmb = dmv_cnt;
    i_dm_req = 1; i_dm_addr = 32'h200; i_dm_we = 0;
    i_if_req = 1; i_if_addr = 32'h40;
    wait_valid(1'b1, 20, "t2_dm_valid");
    i_dm_req = 0;
    check("t2_dm_addr", o_mem_addr, 32'h200);
    check("t2_if_not_yet", o_if_valid, 0);
    wait_valid(1'b0, 20, "t2_if_valid");
    i_if_req = 0;
    check("t2_if_addr", o_mem_addr, 32'h40);
    tick();
    check("t2_dm_pulses", dmv_cnt - dmb, 1);
    check("t2_if_pulses", ifv_cnt - ifb, 1);
    tick();

    // DM write keeps previous read data
    mem_wait = 0; mem_rdata_val = 32'hBAD0BAD0;
    i_dm_req = 1; i_dm_we = 1; i_dm_be = 4'b0011;
    i_dm_addr = 32'h300; i_dm_wdata = 32'h12345678;
    tick();
    check("t3_mem_we", o_mem_we, 1);
    check("t3_mem_be", o_mem_be, 4'b0011);
    check("t3_mem_wdata", o_mem_wdata, 32'h12345678);
    wait_valid(1'b1, 10, "t3_dm_valid");
    i_dm_req = 0; i_dm_we = 0;
    check("t3_rdata_kept", o_dm_rdata, 32'hCAFE0002);
    repeat (2) tick();

    // IF timeout, then a late ack
    mem_silent = 1;
    base = req_hi;
    i_if_req = 1; i_if_addr = 32'h500;
    wait_valid(1'b0, 40, "t4_if_valid");
    i_if_req = 0;
    check("t4_req_cycles", req_hi - base, 15);
    check("t4_if_rdata", o_if_rdata, 0);
    check("t4_err", o_err, 1);
    check("t4_err_src", o_err_src, 0);
    tick();
    late_ack_stim = 1;
    tick();
    late_ack_stim = 0;
    tick();
    check("t4_err_sticky", o_err, 1);
    check("t4_no_late_valid", o_if_valid, 0);
    mem_silent = 0;

    // Asynchronous reset while BUSY_DM
    mem_silent = 1;
    i_dm_req = 1; i_dm_we = 0; i_dm_be = 4'hF; i_dm_addr = 32'h600;
    repeat (3) tick();
    check("t5_busy", o_mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_mem_req", o_mem_req, 0);
    check("t5_rst_err", o_err, 0);
    check("t5_rst_addr", o_mem_addr, 0);
    i_dm_req = 0;
    mem_silent = 0;
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_no_valid", o_dm_valid, 0);
    mem_wait = 1; mem_rdata_val = 32'h0BADF00D;
    i_dm_req = 1; i_dm_addr = 32'h700;
    wait_valid(1'b1, 20, "t5_dm_valid");
    i_dm_req = 0;
    check("t5_rdata", o_dm_rdata, 32'h0BADF00D);
    repeat (2) tick();

    // Back-to-back IF fetches, zero-wait memory
    mem_wait = 0;
    a = 32'h1000;
    i_if_req = 1; i_if_addr = a;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      mem_rdata_val = 32'hA0000000 + k;
      wait_valid(1'b0, 10, "t6_if_valid");
      t_now = $time;
      check("t6_addr", o_mem_addr, a);
      check("t6_rdata", o_if_rdata, 32'hA0000000 + k);
      if (k > 0) check("t6_period", (t_now - t_prev) / 10, 3);
      t_prev = t_now;
      a = a + 4;
      i_if_addr = a;
      if (k == 3) i_if_req = 0;
      tick();
    end
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
